dual_dsp19_mac: RTL and testbench
=================================

# dual_dsp19_mac

Fractured DSP slice: two independent lanes, each a 10x9 multiplier with an optional 32-bit accumulator and a 19-bit output. Lane 1 (A1/B1/Z1) and lane 2 (A2/B2/Z2) share all control inputs. The block is the implementation target for the DSP19X2 primitive in "MULTIPLY" and "MULTIPLY_ACCUMULATE" modes.

## Interface
- DSP_MODE, "MULTIPLY_ACCUMULATE": "MULTIPLY" (combinational product) or "MULTIPLY_ACCUMULATE".
- INPUT_REG_EN, "FALSE": "TRUE" adds an input register stage. Honoured only in accumulate mode.
- COEFF1_0..COEFF1_3, 10'h000: lane 1 A-operand coefficients.
- COEFF2_0..COEFF2_3, 10'h000: lane 2 A-operand coefficients.
- clk  in  1  clock, rising edge.
- lreset  in  1  reset, asynchronous, active-high.
- a1, a2  in  10 each  A operands.
- b1, b2  in  9 each  B operands.
- feedback  in  3  A source select.
- unsigned_a, unsigned_b  in  1 each  1 = operand is unsigned.
- load_acc  in  1  1 = accumulate, 0 = restart.
- subtract  in  1  1 = subtract product.
- shift_right  in  5  output right-shift amount.
- round  in  1  round-half-up on shift.
- saturate  in  1  enable output saturation.
- z1, z2  out  19 each  lane results.

## Operation
- **A source (per lane):**
  - feedback[2]=0 selects the A input.
  - feedback[2]=1 selects COEFFn_[feedback[1:0]].
- **Product:**
  - Operands are extended to 11 bits (A) and 10 bits (B), zero- or sign-extended per unsigned_a / unsigned_b.
  - P is a 19-bit product, sign-extended to 32 bits (zero-extended when both operands are unsigned).
- **MULTIPLY mode:**
  - z = P[18:0], purely combinational.
  - clk, lreset and all accumulator controls are ignored.
- **MULTIPLY_ACCUMULATE mode, accumulator update:**
  - Per lane, a 32-bit ACC updates every clk edge.
  - load_acc=1: ACC <= ACC + P, or ACC − P when subtract=1.
  - load_acc=0: ACC <= P, or −P when subtract=1.
  - ACC wraps modulo 2^32. There is no accumulator saturation.
- **Output path (accumulate mode, combinational from ACC):**
  - Shift: R = ACC >>> shift_right. The shift is arithmetic when signed, logical when both operands are unsigned.
  - Round: when round=1 and shift_right>0, add 1<<(shift_right−1) to ACC before shifting.
  - Saturate, signed: clamp R to [−2^18, 2^18−1] when saturate=1.
  - Saturate, both operands unsigned: clamp R to [0, 2^19−1].
  - Without saturation: z = R[18:0], truncated.
- **Input register (INPUT_REG_EN="TRUE", accumulate mode only):**
  - a1, a2, b1, b2, feedback, unsigned_a, unsigned_b, load_acc and subtract are registered before use.
  - shift_right, round and saturate are never registered.
- **Reset:**
  - ACC and all input registers clear to 0.
  - z1 = z2 = 0 for any shift/round/saturate setting.

## Timing
- MULTIPLY: zero latency.
- Accumulate mode without input register:
  - Inputs sampled at edge N update ACC at edge N.
  - z reflects that update after edge N, i.e. a 1-cycle latency.
- Accumulate mode with input register: 2-cycle latency; ACC lags the inputs by one extra edge.
- lreset asserts z=0 immediately, without waiting for clk. It is held while asserted.
- On lreset deassertion, the first edge processes the current inputs, or the registered zeros when the input register is enabled.
- Reset mid-accumulation discards ACC. Accumulation resumes from 0 only if load_acc=1 on the next edge; otherwise ACC loads P.
- shift_right, round and saturate changes affect z combinationally within the same cycle.

## Test plan
- **MULTIPLY, signed:** a1=10'h3FF (−1), b1=9'd5 -> z1=19'h7FFFB (−5). Same operands with unsigned_a=unsigned_b=1 -> z1=1023·5=5115.
- **Coefficient select:** COEFF2_2=10'd7, feedback=3'b110, b2=9'd3 -> z2=21. With feedback=3'b000, a2=4 -> z2=12.
- **Accumulate, no input register:**
  - Cycle 1: load_acc=0, a1=2, b1=3 -> z1=6.
  - Then three edges with load_acc=1 -> z1=12, 18, 24.
  - Then subtract=1 for one edge -> z1=18.
- **Input register latency:**
  - INPUT_REG_EN="TRUE", reset, then a1=b1=4 with load_acc=0 at edge 1.
  - z1=0 after edge 1; z1=16 after edge 2.
- **Output processing:**
  - ACC=1000, shift_right=3, round=0 -> z=125.
  - ACC=1004, round=1 -> z=126.
  - ACC=2^20, saturate=1, signed -> z=19'h3FFFF. Same with saturate=0 -> z=0, the truncated value.
- **Async reset mid-accumulation:** ACC=500, assert lreset between edges -> z1=z2=0 immediately. Hold through two edges -> still 0.

Source files
------------

// File: rtl/dual_dsp19_mac_if.sv
// Operand, control and result bundle for the dual 10x9 MAC slice.
// The master side drives operands and controls; the slave side returns z1/z2.
interface dual_dsp19_mac_if;
    logic [9:0]  a1;
    logic [9:0]  a2;
    logic [8:0]  b1;
    logic [8:0]  b2;
    logic [2:0]  feedback;
    logic        unsigned_a;
    logic        unsigned_b;
    logic        load_acc;
    logic        subtract;
    logic [4:0]  shift_right;
    logic        round;
    logic        saturate;
    logic [18:0] z1;
    logic [18:0] z2;

    modport master (
        output a1, a2, b1, b2, feedback, unsigned_a, unsigned_b,
               load_acc, subtract, shift_right, round, saturate,
        input  z1, z2
    );

    modport slave (
        input  a1, a2, b1, b2, feedback, unsigned_a, unsigned_b,
               load_acc, subtract, shift_right, round, saturate,
        output z1, z2
    );
endinterface

// File: rtl/dual_dsp19_mac.sv
// Fractured DSP slice: two lanes sharing one control set, each a 10x9
// multiplier feeding an optional 32-bit accumulator with a shift / round /
// saturate output stage producing a 19-bit result.
module dual_dsp19_mac #(
    parameter string      DSP_MODE     = "MULTIPLY_ACCUMULATE",
    parameter string      INPUT_REG_EN = "FALSE",
    parameter logic [9:0] COEFF1_0     = 10'h000,
    parameter logic [9:0] COEFF1_1     = 10'h000,
    parameter logic [9:0] COEFF1_2     = 10'h000,
    parameter logic [9:0] COEFF1_3     = 10'h000,
    parameter logic [9:0] COEFF2_0     = 10'h000,
    parameter logic [9:0] COEFF2_1     = 10'h000,
    parameter logic [9:0] COEFF2_2     = 10'h000,
    parameter logic [9:0] COEFF2_3     = 10'h000
) (
    input  logic             clk,
    input  logic             lreset,
    dual_dsp19_mac_if.slave  bus
);

    // The input register only exists when the accumulator does.
    localparam bit ACC_MODE_C = (DSP_MODE == "MULTIPLY_ACCUMULATE");
    localparam bit IN_REG_C   = ACC_MODE_C && (INPUT_REG_EN == "TRUE");

    // Lane 1 coefficient bank lookup.
    function automatic logic [9:0] coeff1_sel(input logic [1:0] sel);
        logic [9:0] c;
        case (sel)
            2'd0:    c = COEFF1_0;
            2'd1:    c = COEFF1_1;
            2'd2:    c = COEFF1_2;
            2'd3:    c = COEFF1_3;
            default: c = COEFF1_0;
        endcase
        return c;
    endfunction

    // Lane 2 coefficient bank lookup.
    function automatic logic [9:0] coeff2_sel(input logic [1:0] sel);
        logic [9:0] c;
        case (sel)
            2'd0:    c = COEFF2_0;
            2'd1:    c = COEFF2_1;
            2'd2:    c = COEFF2_2;
            2'd3:    c = COEFF2_3;
            default: c = COEFF2_0;
        endcase
        return c;
    endfunction

    // Operands are extended straight to 19 bits: the low 19 bits of that
    // product equal the low 19 bits of the 11x10 extended product.
    function automatic logic [18:0] mul19(input logic [9:0] a, input logic [8:0] b,
                                          input logic ua, input logic ub);
        logic [18:0] a_x;
        logic [18:0] b_x;
        a_x = ua ? {9'd0, a} : {{9{a[9]}}, a};
        b_x = ub ? {10'd0, b} : {{10{b[8]}}, b};
        return a_x * b_x;
    endfunction

    // Widen the 19-bit product for the accumulator.
    function automatic logic [31:0] ext32(input logic [18:0] p, input logic both_u);
        return both_u ? {13'd0, p} : {{13{p[18]}}, p};
    endfunction

    // Accumulator next value; restart uses zero as the base.
    function automatic logic [31:0] acc_next(input logic [31:0] acc, input logic [31:0] p,
                                             input logic load, input logic sub);
        logic [31:0] base;
        base = load ? acc : 32'd0;
        return sub ? (base - p) : (base + p);
    endfunction

    // Round, shift and optionally clamp the accumulator into 19 bits.
    function automatic logic [18:0] out_proc(input logic [31:0] acc, input logic both_u,
                                             input logic [4:0] sh, input logic rnd,
                                             input logic sat);
        logic [31:0] rnd_add;
        logic [31:0] sum;
        logic [31:0] r;
        logic [18:0] z;
        rnd_add = (rnd && (sh != 5'd0)) ? (32'd1 << (sh - 5'd1)) : 32'd0;
        sum     = acc + rnd_add;
        if (both_u) begin
            r = sum >> sh;
            if (sat && (r > 32'd524287)) begin
                z = 19'h7FFFF;
            end else begin
                z = r[18:0];
            end
        end else begin
            r = $unsigned($signed(sum) >>> sh);
            if (sat && ($signed(r) > 32'sd262143)) begin
                z = 19'h3FFFF;
            end else if (sat && ($signed(r) < -32'sd262144)) begin
                z = 19'h40000;
            end else begin
                z = r[18:0];
            end
        end
        return z;
    endfunction

    logic [9:0] a1_s;
    logic [9:0] a2_s;
    logic [8:0] b1_s;
    logic [8:0] b2_s;
    logic [2:0] feedback_s;
    logic       unsigned_a_s;
    logic       unsigned_b_s;
    logic       load_acc_s;
    logic       subtract_s;

    if (IN_REG_C) begin : g_in_reg
        logic [9:0] a1_r;
        logic [9:0] a2_r;
        logic [8:0] b1_r;
        logic [8:0] b2_r;
        logic [2:0] feedback_r;
        logic       unsigned_a_r;
        logic       unsigned_b_r;
        logic       load_acc_r;
        logic       subtract_r;

        // Input stage: capture operands and accumulator controls one edge early.
        always_ff @(posedge clk or posedge lreset) begin
            if (lreset) begin
                a1_r         <= 10'd0;
                a2_r         <= 10'd0;
                b1_r         <= 9'd0;
                b2_r         <= 9'd0;
                feedback_r   <= 3'd0;
                unsigned_a_r <= 1'b0;
                unsigned_b_r <= 1'b0;
                load_acc_r   <= 1'b0;
                subtract_r   <= 1'b0;
            end else begin
                a1_r         <= bus.a1;
                a2_r         <= bus.a2;
                b1_r         <= bus.b1;
                b2_r         <= bus.b2;
                feedback_r   <= bus.feedback;
                unsigned_a_r <= bus.unsigned_a;
                unsigned_b_r <= bus.unsigned_b;
                load_acc_r   <= bus.load_acc;
                subtract_r   <= bus.subtract;
            end
        end

        assign a1_s         = a1_r;
        assign a2_s         = a2_r;
        assign b1_s         = b1_r;
        assign b2_s         = b2_r;
        assign feedback_s   = feedback_r;
        assign unsigned_a_s = unsigned_a_r;
        assign unsigned_b_s = unsigned_b_r;
        assign load_acc_s   = load_acc_r;
        assign subtract_s   = subtract_r;
    end else begin : g_in_direct
        assign a1_s         = bus.a1;
        assign a2_s         = bus.a2;
        assign b1_s         = bus.b1;
        assign b2_s         = bus.b2;
        assign feedback_s   = bus.feedback;
        assign unsigned_a_s = bus.unsigned_a;
        assign unsigned_b_s = bus.unsigned_b;
        assign load_acc_s   = bus.load_acc;
        assign subtract_s   = bus.subtract;
    end

    logic [9:0]  a1_sel_s;
    logic [9:0]  a2_sel_s;
    logic [18:0] p1_s;
    logic [18:0] p2_s;
    logic        both_u_s;

    assign both_u_s = unsigned_a_s & unsigned_b_s;
    assign a1_sel_s = feedback_s[2] ? coeff1_sel(feedback_s[1:0]) : a1_s;
    assign a2_sel_s = feedback_s[2] ? coeff2_sel(feedback_s[1:0]) : a2_s;
    assign p1_s     = mul19(a1_sel_s, b1_s, unsigned_a_s, unsigned_b_s);
    assign p2_s     = mul19(a2_sel_s, b2_s, unsigned_a_s, unsigned_b_s);

    if (ACC_MODE_C) begin : g_acc
        logic [31:0] acc1_r;
        logic [31:0] acc2_r;

        // Per-lane accumulators; reset discards any partial sum.
        always_ff @(posedge clk or posedge lreset) begin
            if (lreset) begin
                acc1_r <= 32'd0;
                acc2_r <= 32'd0;
            end else begin
                acc1_r <= acc_next(acc1_r, ext32(p1_s, both_u_s), load_acc_s, subtract_s);
                acc2_r <= acc_next(acc2_r, ext32(p2_s, both_u_s), load_acc_s, subtract_s);
            end
        end

        // Shift/round/saturate stay live so their changes show up immediately.
        assign bus.z1 = out_proc(acc1_r, both_u_s, bus.shift_right, bus.round, bus.saturate);
        assign bus.z2 = out_proc(acc2_r, both_u_s, bus.shift_right, bus.round, bus.saturate);
    end else begin : g_mul
        assign bus.z1 = p1_s;
        assign bus.z2 = p2_s;
    end

endmodule

// File: tb/tb_dual_dsp19_mac.sv
// Directed bench for dual_dsp19_mac: a pure-multiply instance, an accumulate
// instance and an accumulate instance with the input register, all on one clock.
module tb_dual_dsp19_mac;

    logic clk = 1'b0;
    logic lreset;

    dual_dsp19_mac_if m_if ();
    dual_dsp19_mac_if a_if ();
    dual_dsp19_mac_if r_if ();

    dual_dsp19_mac #(
        .DSP_MODE("MULTIPLY"), .INPUT_REG_EN("FALSE"),
        .COEFF1_0(10'd9), .COEFF1_1(10'd1), .COEFF1_2(10'h3FE), .COEFF1_3(10'd300),
        .COEFF2_0(10'd11), .COEFF2_1(10'd2), .COEFF2_2(10'd7), .COEFF2_3(10'h200)
    ) u_mul (.clk(clk), .lreset(lreset), .bus(m_if));

    dual_dsp19_mac #(
        .DSP_MODE("MULTIPLY_ACCUMULATE"), .INPUT_REG_EN("FALSE"),
        .COEFF1_0(10'd9), .COEFF1_1(10'd1), .COEFF1_2(10'h3FE), .COEFF1_3(10'd300),
        .COEFF2_0(10'd11), .COEFF2_1(10'd2), .COEFF2_2(10'd7), .COEFF2_3(10'h200)
    ) u_acc (.clk(clk), .lreset(lreset), .bus(a_if));

    dual_dsp19_mac #(
        .DSP_MODE("MULTIPLY_ACCUMULATE"), .INPUT_REG_EN("TRUE"),
        .COEFF1_0(10'd9), .COEFF1_1(10'd1), .COEFF1_2(10'h3FE), .COEFF1_3(10'd300),
        .COEFF2_0(10'd11), .COEFF2_1(10'd2), .COEFF2_2(10'd7), .COEFF2_3(10'h200)
    ) u_reg (.clk(clk), .lreset(lreset), .bus(r_if));

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  a1;
        logic [8:0]  b1;
        logic [9:0]  a2;
        logic [8:0]  b2;
        logic [2:0]  fb;
        logic        ua;
        logic        ub;
        logic [18:0] z1;
        logic [18:0] z2;
    } mul_vec_t;

    typedef struct {
        logic        load;
        logic        sub;
        logic [18:0] z1;
        logic [18:0] z2;
    } acc_vec_t;

    mul_vec_t mv[11];
    acc_vec_t av[5];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 19'h%05h expected 19'h%05h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [9:0] a1, input logic [8:0] b1,
                         input logic [9:0] a2, input logic [8:0] b2,
                         input logic load, input logic sub);
        a_if.a1 = a1; a_if.b1 = b1; a_if.a2 = a2; a_if.b2 = b2;
        a_if.load_acc = load; a_if.subtract = sub;
    endtask

    initial begin
        mv[0]  = '{10'h3FF, 9'd5,    10'h000, 9'd0,    3'b000, 1'b0, 1'b0, 19'h7FFFB, 19'h00000};
        mv[1]  = '{10'h3FF, 9'd5,    10'h000, 9'd0,    3'b000, 1'b1, 1'b1, 19'h013FB, 19'h00000};
        mv[2]  = '{10'h3FF, 9'd5,    10'd4,   9'd3,    3'b110, 1'b0, 1'b0, 19'h7FFF6, 19'h00015};
        mv[3]  = '{10'd2,   9'd3,    10'd4,   9'd3,    3'b000, 1'b0, 1'b0, 19'h00006, 19'h0000C};
        mv[4]  = '{10'h3FF, 9'h1FF,  10'h200, 9'h100,  3'b000, 1'b1, 1'b0, 19'h7FC01, 19'h60000};
        mv[5]  = '{10'h200, 9'h1FF,  10'd1,   9'h1FF,  3'b000, 1'b0, 1'b1, 19'h40200, 19'h001FF};
        mv[6]  = '{10'h3FF, 9'h1FF,  10'h200, 9'h100,  3'b000, 1'b1, 1'b1, 19'h7FA01, 19'h20000};
        mv[7]  = '{10'h200, 9'h100,  10'h1FF, 9'h0FF,  3'b000, 1'b0, 1'b0, 19'h20000, 19'h1FD01};
        mv[8]  = '{10'd0,   9'd2,    10'd0,   9'd2,    3'b100, 1'b0, 1'b0, 19'h00012, 19'h00016};
        mv[9]  = '{10'd0,   9'h1FF,  10'd0,   9'h1FF,  3'b101, 1'b0, 1'b0, 19'h7FFFF, 19'h7FFFE};
        mv[10] = '{10'd0,   9'd3,    10'd0,   9'd1,    3'b111, 1'b0, 1'b0, 19'h00384, 19'h7FE00};

        av[0] = '{1'b0, 1'b0, 19'd6,  19'd1};
        av[1] = '{1'b1, 1'b0, 19'd12, 19'd2};
        av[2] = '{1'b1, 1'b0, 19'd18, 19'd3};
        av[3] = '{1'b1, 1'b0, 19'd24, 19'd4};
        av[4] = '{1'b1, 1'b1, 19'd18, 19'd3};

        lreset = 1'b1;
        m_if.a1 = 10'd0; m_if.a2 = 10'd0; m_if.b1 = 9'd0; m_if.b2 = 9'd0;
        m_if.feedback = 3'd0; m_if.unsigned_a = 1'b0; m_if.unsigned_b = 1'b0;
        m_if.load_acc = 1'b0; m_if.subtract = 1'b0; m_if.shift_right = 5'd0;
        m_if.round = 1'b0; m_if.saturate = 1'b0;
        a_if.a1 = 10'd0; a_if.a2 = 10'd0; a_if.b1 = 9'd0; a_if.b2 = 9'd0;
        a_if.feedback = 3'd0; a_if.unsigned_a = 1'b0; a_if.unsigned_b = 1'b0;
        a_if.load_acc = 1'b0; a_if.subtract = 1'b0; a_if.shift_right = 5'd3;
        a_if.round = 1'b1; a_if.saturate = 1'b1;
        r_if.a1 = 10'd0; r_if.a2 = 10'd0; r_if.b1 = 9'd0; r_if.b2 = 9'd0;
        r_if.feedback = 3'd0; r_if.unsigned_a = 1'b0; r_if.unsigned_b = 1'b0;
        r_if.load_acc = 1'b0; r_if.subtract = 1'b0; r_if.shift_right = 5'd3;
        r_if.round = 1'b1; r_if.saturate = 1'b1;

        #3;
        chk("reset_acc_z1", a_if.z1, 19'd0);
        chk("reset_acc_z2", a_if.z2, 19'd0);
        chk("reset_reg_z1", r_if.z1, 19'd0);

        // Multiply-only instance runs while lreset is high: it must not care.
        for (int i = 0; i < 11; i++) begin
            m_if.a1 = mv[i].a1; m_if.b1 = mv[i].b1;
            m_if.a2 = mv[i].a2; m_if.b2 = mv[i].b2;
            m_if.feedback = mv[i].fb;
            m_if.unsigned_a = mv[i].ua; m_if.unsigned_b = mv[i].ub;
            #1;
            chk($sformatf("mul_z1[%0d]", i), m_if.z1, mv[i].z1);
            chk($sformatf("mul_z2[%0d]", i), m_if.z2, mv[i].z2);
        end

        // Accumulate sequence, with the input-register latency checked alongside.
        a_if.shift_right = 5'd0; a_if.round = 1'b0; a_if.saturate = 1'b0;
        r_if.shift_right = 5'd0; r_if.round = 1'b0; r_if.saturate = 1'b0;
        set_a(10'd2, 9'd3, 10'd1, 9'd1, 1'b0, 1'b0);
        r_if.a1 = 10'd4; r_if.b1 = 9'd4; r_if.load_acc = 1'b0;
        @(negedge clk);
        lreset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_if.load_acc = av[i].load;
            a_if.subtract = av[i].sub;
            step();
            chk($sformatf("acc_z1[%0d]", i), a_if.z1, av[i].z1);
            chk($sformatf("acc_z2[%0d]", i), a_if.z2, av[i].z2);
            if (i == 0) chk("inreg_edge1", r_if.z1, 19'd0);
            if (i == 1) chk("inreg_edge2", r_if.z1, 19'd16);
        end

        // Output stage: shift and round.
        set_a(10'd25, 9'd40, 10'd0, 9'd0, 1'b0, 1'b0);
        step();
        a_if.shift_right = 5'd3;
        #1 chk("shift_1000", a_if.z1, 19'd125);
        set_a(10'd251, 9'd4, 10'd0, 9'd0, 1'b0, 1'b0);
        step();
        chk("shift_1004", a_if.z1, 19'd125);
        a_if.round = 1'b1;
        #1 chk("round_1004", a_if.z1, 19'd126);

        // Build ACC1 = 2^20 and ACC2 = -1044480 for saturation.
        a_if.round = 1'b0; a_if.shift_right = 5'd0;
        set_a(10'h200, 9'h100, 10'h200, 9'h0FF, 1'b0, 1'b0);
        step();
        a_if.load_acc = 1'b1;
        repeat (7) step();
        a_if.saturate = 1'b1;
        #1 chk("sat_pos", a_if.z1, 19'h3FFFF);
        chk("sat_neg", a_if.z2, 19'h40000);
        a_if.saturate = 1'b0;
        #1 chk("trunc_pos", a_if.z1, 19'h00000);
        chk("trunc_neg", a_if.z2, 19'h01000);
        a_if.shift_right = 5'd4;
        #1 chk("ashr_pos", a_if.z1, 19'h10000);
        chk("ashr_neg", a_if.z2, 19'h70100);

        // Unsigned output path: ACC1 = 2 * 1023 * 511.
        a_if.shift_right = 5'd0;
        a_if.unsigned_a = 1'b1; a_if.unsigned_b = 1'b1;
        set_a(10'h3FF, 9'h1FF, 10'd0, 9'd0, 1'b0, 1'b0);
        step();
        a_if.load_acc = 1'b1;
        step();
        a_if.saturate = 1'b1;
        #1 chk("usat", a_if.z1, 19'h7FFFF);
        a_if.saturate = 1'b0;
        #1 chk("utrunc", a_if.z1, 19'h7F402);
        a_if.shift_right = 5'd1;
        #1 chk("ushr", a_if.z1, 19'h7FA01);

        // Async reset in the middle of accumulation.
        a_if.shift_right = 5'd0;
        a_if.unsigned_a = 1'b0; a_if.unsigned_b = 1'b0;
        set_a(10'd20, 9'd25, 10'd10, 9'd50, 1'b0, 1'b0);
        step();
        chk("pre_rst_z1", a_if.z1, 19'd500);
        chk("pre_rst_z2", a_if.z2, 19'd500);
        #2 lreset = 1'b1;
        #1 chk("rst_imm_z1", a_if.z1, 19'd0);
        chk("rst_imm_z2", a_if.z2, 19'd0);
        a_if.load_acc = 1'b1;
        step();
        chk("rst_hold1_z1", a_if.z1, 19'd0);
        step();
        chk("rst_hold2_z1", a_if.z1, 19'd0);
        chk("rst_hold2_z2", a_if.z2, 19'd0);
        a_if.shift_right = 5'd2; a_if.round = 1'b1; a_if.saturate = 1'b1;
        #1 chk("rst_rnd_z1", a_if.z1, 19'd0);
        a_if.shift_right = 5'd0; a_if.round = 1'b0; a_if.saturate = 1'b0;
        @(negedge clk);
        lreset = 1'b0;
        step();
        chk("resume_z1", a_if.z1, 19'd500);
        chk("resume_z2", a_if.z2, 19'd500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
